interlock_route_requester: RTL
==============================

Name: interlock_route_requester

Overview:
- Sequential requester that drives the request (section-occupy) input of a ring interlock section and interprets the interlock's permit output.
- Turns an operator route request into a timed protocol: assert the request, let the neighbouring interlock logic settle, confirm the permit, hold the grant, then release with a guard interval.
- Sits between operator/route-setting logic and one interlock section; one instance per ring section.

Parameters:
- SETTLE_CYC, 4, cycles o_req is held before i_permit is sampled (min 1)
- CONFIRM_CYC, 8, consecutive cycles i_permit must be 1 before grant (min 1)
- HOLD_MIN, 16, minimum cycles in GRANTED before a release is honoured (min 1)
- CNT_W, 16, counter width; must hold max(SETTLE_CYC, CONFIRM_CYC, HOLD_MIN)

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  operator route request, level; 1 = want section
- i_cancel  in  1  abort/release request, level
- i_permit  in  1  interlock permit output for this section; 1 = no conflict
- o_req  out  1  request to the interlock section input (occupy)
- o_granted  out  1  route granted and held
- o_denied  out  1  request refused or grant lost
- o_busy  out  1  FSM not in IDLE
- o_state  out  3  FSM state code, for debug

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0: state=IDLE, cnt=0, armed=0, and all outputs are 0. Reset mid-operation drops o_req immediately with no RELEASE guard.
- All outputs are registered, decoded from the next state. There is no combinational path from inputs to outputs.
- armed flag: set in IDLE when i_req=0; cleared on leaving IDLE. A request held high through reset, or held across a previous session, must drop before it is accepted again.
- State codes: IDLE=0, ASSERT=1, CONFIRM=2, GRANTED=3, RELEASE=4, DENIED=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE: o_req=0. If i_req=1 and armed=1 and i_cancel=0: go to ASSERT, cnt=0.
- ASSERT: o_req=1. i_permit is ignored.
  - If i_cancel=1: go to RELEASE, cnt=0.
  - Else if cnt=SETTLE_CYC-1: go to CONFIRM, cnt=0.
  - Else cnt++.
- CONFIRM: o_req=1. Evaluated in priority order:
  - i_cancel=1 or i_req=0: go to RELEASE.
  - i_permit=0: go to DENIED.
  - cnt=CONFIRM_CYC-1: go to GRANTED, cnt=0.
  - Otherwise cnt++.
- GRANTED: o_req=1, o_granted=1. cnt counts up and saturates at HOLD_MIN.
  - If i_permit=0: go to DENIED. This takes priority over release.
  - Else if (i_req=0 or i_cancel=1) and cnt>=HOLD_MIN-1: go to RELEASE, cnt=0.
  - A release attempted before HOLD_MIN is deferred, not lost: it is honoured once cnt>=HOLD_MIN-1 if still present.
- RELEASE: o_req=0. Held for SETTLE_CYC cycles as a guard, then go to IDLE. Requests are ignored in this state.
- DENIED: o_req=0, o_denied=1. Stays until i_req=0, then goes to RELEASE, cnt=0.
- o_busy=1 in every state except IDLE.
- Latency: with i_req rising at edge k, o_req is 1 after edge k+1. o_granted rises SETTLE_CYC+CONFIRM_CYC cycles after o_req rises, provided i_permit stays 1.
- Simultaneous i_req and i_cancel in IDLE: no start.

Test Plan:
1. Reset with i_req=1 held, then release reset → no o_req. Drop i_req for 1 cycle, raise it again → o_req=1, and o_granted=1 exactly 12 cycles later with i_permit=1.
2. Grant, then drop i_req after 5 cycles in GRANTED → o_granted stays 1 until 16 cycles have elapsed in GRANTED, then o_req=0 for 4 RELEASE cycles, then o_busy=0.
3. i_permit=0 on the 3rd CONFIRM cycle → o_req=0, o_denied=1 the next cycle and held. Drop i_req → o_denied=0, then RELEASE for 4 cycles, then IDLE.
4. In GRANTED, pulse i_permit=0 for 1 cycle while i_req=0 and HOLD_MIN is satisfied → state goes to DENIED, not RELEASE, and o_granted falls.
5. i_cancel=1 during ASSERT (2nd cycle) → RELEASE; o_granted never rises; o_state sequence is 1,4,0.
6. Assert i_rst_n=0 asynchronously mid-GRANTED → o_req, o_granted and o_busy go to 0 before the next clock edge.

Source files
------------

// File: rtl/interlock_route_requester.sv
// interlock_route_requester
//
// Drives the occupy request of one ring interlock section and interprets that
// section's permit. An operator route request becomes a timed handshake:
// raise the request, let neighbouring interlock logic settle, confirm the
// permit holds for a window, hold the grant for at least a minimum time, then
// drop the request behind a guard interval.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_req      operator route request (level, 1 = want section)
//   i_cancel   abort / release request (level)
//   i_permit   interlock permit for this section (1 = no conflict)
//   o_req      occupy request to the interlock section
//   o_granted  route granted and held
//   o_denied   request refused or grant lost
//   o_busy     FSM not idle
//   o_state    FSM state code (debug)
//
// All outputs are registered and decoded from the next state, so nothing
// combinational reaches an output from an input.

module interlock_route_requester #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned CONFIRM_CYC = 8,
    parameter int unsigned HOLD_MIN    = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic       i_cancel,
    input  logic       i_permit,
    output logic       o_req,
    output logic       o_granted,
    output logic       o_denied,
    output logic       o_busy,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAssert  = 3'd1,
        StConfirm = 3'd2,
        StGranted = 3'd3,
        StRelease = 3'd4,
        StDenied  = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ConfirmLast = CNT_W'(CONFIRM_CYC - 1);
    localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_MIN - 1);
    localparam logic [CNT_W-1:0] HoldSat     = CNT_W'(HOLD_MIN);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    logic             req_d;
    logic             granted_d;
    logic             denied_d;
    logic             busy_d;
    logic             release_req;

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        release_req = ~i_req | i_cancel;

        case (state_q)
            StIdle: begin
                // A request must be seen low in IDLE before it is accepted, so a
                // level held through reset or a previous session cannot restart.
                if (!i_req) begin
                    armed_d = 1'b1;
                end
                if (i_req && armed_q && !i_cancel) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end

            StAssert: begin
                // Permit is not meaningful until the neighbours have settled.
                if (i_cancel) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else if (cnt_q == SettleLast) begin
                    state_d = StConfirm;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StConfirm: begin
                if (release_req) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else if (!i_permit) begin
                    state_d = StDenied;
                    cnt_d   = '0;
                end else if (cnt_q == ConfirmLast) begin
                    state_d = StGranted;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StGranted: begin
                if (cnt_q < HoldSat) begin
                    cnt_d = cnt_q + CntOne;
                end
                // Loss of permit wins over release; an early release is simply
                // re-evaluated each cycle until the hold time is met.
                if (!i_permit) begin
                    state_d = StDenied;
                    cnt_d   = '0;
                end else if (release_req && (cnt_q >= HoldLast)) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end

            StRelease: begin
                if (cnt_q == SettleLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StDenied: begin
                if (!i_req) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end

            default: begin
                // Unused codes recover to IDLE disarmed.
                state_d = StIdle;
                cnt_d   = '0;
                armed_d = 1'b0;
            end
        endcase
    end

    // Output decode from the next state.
    always_comb begin
        req_d     = 1'b0;
        granted_d = 1'b0;
        denied_d  = 1'b0;
        busy_d    = (state_d != StIdle);

        case (state_d)
            StAssert,
            StConfirm: begin
                req_d = 1'b1;
            end
            StGranted: begin
                req_d     = 1'b1;
                granted_d = 1'b1;
            end
            StDenied: begin
                denied_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            o_req     <= 1'b0;
            o_granted <= 1'b0;
            o_denied  <= 1'b0;
            o_busy    <= 1'b0;
            o_state   <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            o_req     <= req_d;
            o_granted <= granted_d;
            o_denied  <= denied_d;
            o_busy    <= busy_d;
            o_state   <= state_d;
        end
    end

endmodule
